// File: rtl/cdb_broadcast_arbiter_pkg.sv
// Shared definitions for the result-broadcast (CDB) arbiter: bus widths,
// producer indices, the queued entry layout and the wrap-safe age compare.
package cdb_broadcast_arbiter_pkg;

  localparam int MAP_W  = 6;
  localparam int DATA_W = 32;
  localparam int NUM_W  = 32;
  localparam int SRC_W  = 2;

  localparam int CDB_EXE  = 0;
  localparam int CDB_MEM  = 1;
  localparam int CDB_HILO = 2;

  typedef struct packed {
    logic [MAP_W-1:0]  map;
    logic [DATA_W-1:0] val;
    logic [NUM_W-1:0]  instr_num;
  } cdb_entry_t;

  // a is older than b when the modular distance a-b is negative, so the
  // ordering survives instruction-number wraparound.
  function automatic logic is_older(input logic [NUM_W-1:0] a,
                                    input logic [NUM_W-1:0] b);
    logic signed [NUM_W-1:0] diff;
    diff = $signed(a - b);
    return (diff < 0);
  endfunction

endpackage

// File: rtl/cdb_req_fifo.sv
// Per-producer skid FIFO: DEPTH-entry circular buffer holding results that
// are waiting for the broadcast bus. Flush empties it synchronously and wins
// over push/pop. The caller guarantees no push when full and no pop when empty.
module cdb_req_fifo
  import cdb_broadcast_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  cdb_entry_t               i_din,
  input  logic                     i_pop,
  output cdb_entry_t               o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  cdb_entry_t       r_mem [DEPTH];

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; payload needs no reset because occupancy gates its use
  always_ff @(posedge CLK) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/cdb_broadcast_arbiter.sv
// Result-broadcast arbiter: each producer (ALU, load return, hi/lo unit)
// queues results in its own skid FIFO; every cycle the oldest queued head
// (by ROB instruction number, ties to the lower producer index) is popped
// and driven onto the registered broadcast bus. The idle bus is all zeros.
module cdb_broadcast_arbiter
  import cdb_broadcast_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DEPTH   = 2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      FLUSH,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*MAP_W-1:0]  req_map,
  input  logic [NUM_REQ*DATA_W-1:0] req_val,
  input  logic [NUM_REQ*NUM_W-1:0]  req_instr_num,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      bcast_valid,
  output logic [MAP_W-1:0]          bcast_map,
  output logic [DATA_W-1:0]         bcast_val,
  output logic [NUM_W-1:0]          bcast_instr_num,
  output logic [SRC_W-1:0]          bcast_src,
  output logic                      halt_issue
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]   w_count [NUM_REQ];
  cdb_entry_t         w_head  [NUM_REQ];
  cdb_entry_t         w_din   [NUM_REQ];
  logic [NUM_REQ-1:0] w_full;
  logic [NUM_REQ-1:0] w_nonempty;
  logic [NUM_REQ-1:0] w_push;
  logic [NUM_REQ-1:0] w_pop;

  logic               w_sel_valid;
  logic [SRC_W-1:0]   w_sel_idx;
  cdb_entry_t         w_sel_entry;

  logic               r_bcast_vld_p1;
  cdb_entry_t         r_bcast_entry_p1;
  logic [SRC_W-1:0]   r_bcast_src_p1;
  logic               r_halt_p1;

  for (genvar p = 0; p < NUM_REQ; p++) begin : g_req
    // Ready comes only from registered occupancy, so there is no valid->ready path.
    assign w_full[p]     = (w_count[p] == CNT_W'(DEPTH));
    assign w_nonempty[p] = (w_count[p] != '0);
    assign req_ready[p]  = ~w_full[p];
    // A result with no destination register completes its handshake but is dropped.
    assign w_push[p]     = req_valid[p] & ~w_full[p] &
                           (req_map[p*MAP_W +: MAP_W] != '0);
    assign w_pop[p]      = w_sel_valid & (w_sel_idx == SRC_W'(p));
    assign w_din[p]      = {req_map[p*MAP_W +: MAP_W],
                            req_val[p*DATA_W +: DATA_W],
                            req_instr_num[p*NUM_W +: NUM_W]};

    cdb_req_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .CLK     (CLK),
      .RESET   (RESET),
      .i_flush (FLUSH),
      .i_push  (w_push[p]),
      .i_din   (w_din[p]),
      .i_pop   (w_pop[p]),
      .o_head  (w_head[p]),
      .o_count (w_count[p])
    );
  end

  // Oldest-first pick among non-empty heads; strict compare keeps the lower index on ties
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    w_sel_entry = '0;
    for (int p = 0; p < NUM_REQ; p++) begin
      if (w_nonempty[p] &&
          (!w_sel_valid || is_older(w_head[p].instr_num, w_sel_entry.instr_num))) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = SRC_W'(p);
        w_sel_entry = w_head[p];
      end
    end
  end

  // Broadcast register (stage p1): winner copied out, zeroed bus when idle or flushed
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_bcast_vld_p1   <= 1'b0;
      r_bcast_entry_p1 <= '0;
      r_bcast_src_p1   <= '0;
    end else if (FLUSH) begin
      r_bcast_vld_p1   <= 1'b0;
      r_bcast_entry_p1 <= '0;
      r_bcast_src_p1   <= '0;
    end else begin
      r_bcast_vld_p1   <= w_sel_valid;
      r_bcast_entry_p1 <= w_sel_valid ? w_sel_entry : '0;
      r_bcast_src_p1   <= w_sel_valid ? w_sel_idx : '0;
    end
  end

  // Issue back-pressure: raised the cycle after any FIFO is seen full
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_halt_p1 <= 1'b0;
    end else if (FLUSH) begin
      r_halt_p1 <= 1'b0;
    end else begin
      r_halt_p1 <= |w_full;
    end
  end

  assign bcast_valid     = r_bcast_vld_p1;
  assign bcast_map       = r_bcast_entry_p1.map;
  assign bcast_val       = r_bcast_entry_p1.val;
  assign bcast_instr_num = r_bcast_entry_p1.instr_num;
  assign bcast_src       = r_bcast_src_p1;
  assign halt_issue      = r_halt_p1;

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Bench for the result-broadcast arbiter: directed scenarios drive producers,
// push the broadcasts they should cause (in age order) into a scoreboard, and
// a monitor pops and compares every broadcast that appears on the bus.
module tb_cdb_broadcast_arbiter;
  import cdb_broadcast_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int DP = 2;

  logic                 CLK = 1'b0;
  logic                 RESET;
  logic                 FLUSH;
  logic [NR-1:0]        req_valid;
  logic [NR*MAP_W-1:0]  req_map;
  logic [NR*DATA_W-1:0] req_val;
  logic [NR*NUM_W-1:0]  req_instr_num;
  logic [NR-1:0]        req_ready;
  logic                 bcast_valid;
  logic [MAP_W-1:0]     bcast_map;
  logic [DATA_W-1:0]    bcast_val;
  logic [NUM_W-1:0]     bcast_instr_num;
  logic [SRC_W-1:0]     bcast_src;
  logic                 halt_issue;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [MAP_W-1:0]  map;
    logic [DATA_W-1:0] val;
    logic [NUM_W-1:0]  num;
    logic [SRC_W-1:0]  src;
  } exp_t;
  exp_t sb[$];

  cdb_broadcast_arbiter #(.NUM_REQ(NR), .DEPTH(DP)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .FLUSH           (FLUSH),
    .req_valid       (req_valid),
    .req_map         (req_map),
    .req_val         (req_val),
    .req_instr_num   (req_instr_num),
    .req_ready       (req_ready),
    .bcast_valid     (bcast_valid),
    .bcast_map       (bcast_map),
    .bcast_val       (bcast_val),
    .bcast_instr_num (bcast_instr_num),
    .bcast_src       (bcast_src),
    .halt_issue      (halt_issue)
  );

  always #5 CLK = ~CLK;

  // Scoreboard monitor: every broadcast must match the next expected entry
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (bcast_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_bcast: got map=%0d num=%0h src=%0d, required no broadcast",
                 bcast_map, bcast_instr_num, bcast_src);
      end else begin
        e = sb.pop_front();
        if (bcast_map !== e.map || bcast_val !== e.val ||
            bcast_instr_num !== e.num || bcast_src !== e.src) begin
          errors++;
          $display("FAIL bcast_content: got map=%0d val=%0h num=%0h src=%0d, required map=%0d val=%0h num=%0h src=%0d",
                   bcast_map, bcast_val, bcast_instr_num, bcast_src, e.map, e.val, e.num, e.src);
        end
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs;
    req_valid     = '0;
    req_map       = '0;
    req_val       = '0;
    req_instr_num = '0;
  endtask

  task automatic drive(input int p, input logic [MAP_W-1:0] m,
                       input logic [DATA_W-1:0] v, input logic [NUM_W-1:0] n);
    req_valid[p]                   = 1'b1;
    req_map[p*MAP_W +: MAP_W]      = m;
    req_val[p*DATA_W +: DATA_W]    = v;
    req_instr_num[p*NUM_W +: NUM_W] = n;
  endtask

  task automatic expect_bc(input logic [MAP_W-1:0] m, input logic [DATA_W-1:0] v,
                           input logic [NUM_W-1:0] n, input logic [SRC_W-1:0] s);
    exp_t e;
    e.map = m; e.val = v; e.num = n; e.src = s;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    RESET = 1'b0;
    FLUSH = 1'b0;
    idle_inputs();
    #12;
    checks++; if (bcast_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b, required 0", bcast_valid); end
    checks++; if (bcast_map !== '0) begin errors++; $display("FAIL rst_map: got %0d, required 0", bcast_map); end
    checks++; if (bcast_val !== '0) begin errors++; $display("FAIL rst_val: got %0h, required 0", bcast_val); end
    checks++; if (bcast_instr_num !== '0) begin errors++; $display("FAIL rst_num: got %0h, required 0", bcast_instr_num); end
    checks++; if (bcast_src !== '0) begin errors++; $display("FAIL rst_src: got %0d, required 0", bcast_src); end
    checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL rst_ready: got %b, required 111", req_ready); end
    checks++; if (halt_issue !== 1'b0) begin errors++; $display("FAIL rst_halt: got %0b, required 0", halt_issue); end
    @(negedge CLK);
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_single;
    drive(CDB_EXE, 6'd5, 32'hDEADBEEF, 32'd10);
    expect_bc(6'd5, 32'hDEADBEEF, 32'd10, 2'd0);
    tick();
    idle_inputs();
    checks++; if (bcast_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %0b, required 0", bcast_valid); end
    tick();
    checks++; if (bcast_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b, required 1", bcast_valid); end
    tick();
    checks++; if (bcast_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got %0b, required 0", bcast_valid); end
    checks++; if (bcast_map !== '0) begin errors++; $display("FAIL single_idle_map: got %0d, required 0", bcast_map); end
  endtask

  task automatic test_age_order;
    drive(CDB_EXE, 6'd3, 32'h33, 32'd7);
    drive(CDB_MEM, 6'd4, 32'h44, 32'd5);
    expect_bc(6'd4, 32'h44, 32'd5, 2'd1);
    expect_bc(6'd3, 32'h33, 32'd7, 2'd0);
    tick();
    idle_inputs();
    tick();
    checks++; if (bcast_src !== 2'd1) begin errors++; $display("FAIL age_first_src: got %0d, required 1", bcast_src); end
    tick();
    checks++; if (bcast_src !== 2'd0) begin errors++; $display("FAIL age_second_src: got %0d, required 0", bcast_src); end
    tick();
  endtask

  task automatic test_wrap;
    drive(CDB_HILO, 6'd10, 32'hA, 32'hFFFF_FFFF);
    drive(CDB_EXE,  6'd11, 32'hB, 32'h0000_0001);
    expect_bc(6'd10, 32'hA, 32'hFFFF_FFFF, 2'd2);
    expect_bc(6'd11, 32'hB, 32'h0000_0001, 2'd0);
    tick();
    idle_inputs();
    tick();
    checks++; if (bcast_src !== 2'd2) begin errors++; $display("FAIL wrap_first_src: got %0d, required 2", bcast_src); end
    tick();
    checks++; if (bcast_src !== 2'd0) begin errors++; $display("FAIL wrap_second_src: got %0d, required 0", bcast_src); end
    tick();
  endtask

  task automatic test_tie;
    drive(CDB_HILO, 6'd12, 32'hC2, 32'd40);
    drive(CDB_EXE,  6'd13, 32'hC0, 32'd40);
    expect_bc(6'd13, 32'hC0, 32'd40, 2'd0);
    expect_bc(6'd12, 32'hC2, 32'd40, 2'd2);
    tick();
    idle_inputs();
    tick();
    tick();
    tick();
    checks++; if (bcast_valid !== 1'b0) begin errors++; $display("FAIL tie_idle: got %0b, required 0", bcast_valid); end
  endtask

  task automatic test_back_to_back;
    expect_bc(6'd30, 32'd100, 32'd1, 2'd0);
    expect_bc(6'd30, 32'd101, 32'd1, 2'd0);
    expect_bc(6'd30, 32'd102, 32'd1, 2'd0);
    expect_bc(6'd20, 32'd200, 32'd10, 2'd1);
    expect_bc(6'd21, 32'd201, 32'd11, 2'd1);
    expect_bc(6'd22, 32'd202, 32'd12, 2'd1);
    drive(CDB_EXE, 6'd30, 32'd100, 32'd1);
    drive(CDB_MEM, 6'd20, 32'd200, 32'd10);
    tick();
    checks++; if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL b2b_ready_one: got %0b, required 1", req_ready[1]); end
    drive(CDB_EXE, 6'd30, 32'd101, 32'd1);
    drive(CDB_MEM, 6'd21, 32'd201, 32'd11);
    tick();
    checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %0b, required 0", req_ready[1]); end
    checks++; if (halt_issue !== 1'b0) begin errors++; $display("FAIL b2b_halt_early: got %0b, required 0", halt_issue); end
    drive(CDB_EXE, 6'd30, 32'd102, 32'd1);
    drive(CDB_MEM, 6'd22, 32'd202, 32'd12);
    tick();
    checks++; if (halt_issue !== 1'b1) begin errors++; $display("FAIL b2b_halt: got %0b, required 1", halt_issue); end
    checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL b2b_still_full: got %0b, required 0", req_ready[1]); end
    req_valid[0] = 1'b0;
    tick();
    checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL b2b_hold_ready: got %0b, required 0", req_ready[1]); end
    tick();
    checks++; if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL b2b_ready_back: got %0b, required 1", req_ready[1]); end
    checks++; if (halt_issue !== 1'b1) begin errors++; $display("FAIL b2b_halt_lag: got %0b, required 1", halt_issue); end
    tick();
    idle_inputs();
    checks++; if (halt_issue !== 1'b0) begin errors++; $display("FAIL b2b_halt_clear: got %0b, required 0", halt_issue); end
    tick();
    tick();
    checks++; if (bcast_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %0b, required 0", bcast_valid); end
    checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL b2b_ready_all: got %b, required 111", req_ready); end
  endtask

  task automatic test_null_map;
    drive(CDB_EXE, 6'd0, 32'h55, 32'd50);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL null_ready_%0d: got %0b, required 1", i, req_ready[0]); end
    end
    idle_inputs();
    tick();
    tick();
    checks++; if (bcast_valid !== 1'b0) begin errors++; $display("FAIL null_no_bcast: got %0b, required 0", bcast_valid); end
  endtask

  task automatic test_flush;
    drive(CDB_EXE, 6'd1, 32'h60, 32'd60);
    drive(CDB_MEM, 6'd2, 32'h61, 32'd61);
    tick();
    idle_inputs();
    FLUSH = 1'b1;
    drive(CDB_HILO, 6'd3, 32'h62, 32'd62);
    tick();
    FLUSH = 1'b0;
    idle_inputs();
    checks++; if (bcast_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b, required 0", bcast_valid); end
    checks++; if (bcast_map !== '0) begin errors++; $display("FAIL flush_map: got %0d, required 0", bcast_map); end
    checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL flush_ready: got %b, required 111", req_ready); end
    checks++; if (halt_issue !== 1'b0) begin errors++; $display("FAIL flush_halt: got %0b, required 0", halt_issue); end
    tick();
    tick();
    tick();
    checks++; if (bcast_valid !== 1'b0) begin errors++; $display("FAIL flush_stale: got %0b, required 0", bcast_valid); end
  endtask

  task automatic test_reset_mid;
    drive(CDB_EXE, 6'd5, 32'h70, 32'd70);
    expect_bc(6'd5, 32'h70, 32'd70, 2'd0);
    tick();
    drive(CDB_EXE, 6'd6, 32'h71, 32'd71);
    tick();
    idle_inputs();
    #2;
    RESET = 1'b0;
    #1;
    checks++; if (bcast_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b, required 0", bcast_valid); end
    checks++; if (bcast_map !== '0) begin errors++; $display("FAIL rstmid_map: got %0d, required 0", bcast_map); end
    checks++; if (bcast_instr_num !== '0) begin errors++; $display("FAIL rstmid_num: got %0h, required 0", bcast_instr_num); end
    checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL rstmid_ready: got %b, required 111", req_ready); end
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bcast_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale_%0d: got %0b, required 0", i, bcast_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_age_order();
    test_wrap();
    test_tie();
    test_back_to_back();
    test_null_map();
    test_flush();
    test_reset_mid();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending broadcasts, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
